// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and default sizing for the round-robin grant scheduler.
// State encodings live here so the FSM and any debug logic agree on them.
package rr_grant_scheduler_pkg;

    localparam int RR_NREQ     = 4;
    localparam int RR_MAX_HOLD = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the clients (master) and the scheduler (slave).
// Grant-side signals are all registered inside the scheduler.
interface rr_grant_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [IDW-1:0]  gnt_id;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, timeout
    );
endinterface

// File: rtl/rr_grant_scheduler_priority_pick.sv
// Rotating priority search: first set request at or after ptr, wrapping mod NREQ.
// Purely combinational; explicit wrap compare so non-power-of-2 NREQ works.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            any_o,
    output logic [IDW-1:0]  win_id_o
);

    int idx;

    // Scan from farthest to nearest so the last hit is the closest to ptr.
    always_comb begin
        any_o    = 1'b0;
        win_id_o = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_i[idx]) begin
                any_o    = 1'b1;
                win_id_o = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner of one shared resource: 1-cycle req->gnt, grant held until done,
// request drop or MAX_HOLD watchdog; always one idle cycle between owners, no preemption.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int NREQ     = RR_NREQ,
    parameter int MAX_HOLD = RR_MAX_HOLD,
    parameter int IDW      = $clog2(NREQ),
    parameter int CNTW     = $clog2(MAX_HOLD + 1)
) (
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    rr_grant_scheduler_if.slave   bus
);

    sched_state_e    state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            timeout_q, timeout_d;

    logic            pick_any;
    logic [IDW-1:0]  pick_id;
    logic            owner_req;
    logic            at_limit;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .win_id_o (pick_id)
    );

    assign owner_req = bus.req[gnt_id_q];
    assign at_limit  = (cnt_q == CNTW'(MAX_HOLD));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                cnt_d       = '0;
                if (pick_any) begin
                    gnt_d[pick_id] = 1'b1;
                    gnt_valid_d    = 1'b1;
                    gnt_id_d       = pick_id;
                    cnt_d          = CNTW'(1);
                    state_d        = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.done || !owner_req || at_limit) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                    ptr_d       = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
                    // Watchdog only flagged when nothing else would have released the grant.
                    timeout_d   = at_limit && !bus.done && owner_req;
                end else if (!at_limit) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (NREQ=4, MAX_HOLD=8); inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_rr_grant_scheduler;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;

    rr_grant_scheduler_if #(.NREQ(4), .IDW(2)) bus ();

    rr_grant_scheduler #(
        .NREQ     (4),
        .MAX_HOLD (8)
    ) dut (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic to);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".vld"}, 32'(bus.gnt_valid), 32'(|g));
        chk({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
        chk({tag, ".to"}, 32'(bus.timeout), 32'(to));
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    logic [3:0] rot_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rot_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        n_rst    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;

        // Reset held with all requests active: nothing granted.
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("rst_hold", 4'b0000, 2'd0, 1'b0);
        end
        n_rst = 1'b1;
        step();
        chk_out("rst_exit_gnt", 4'b0001, 2'd0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk_out("rst_async", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b0000;
        step();
        n_rst = 1'b1;
        step();
        chk_out("idle_noreq", 4'b0000, 2'd0, 1'b0);

        // Single requester with done.
        bus.done = 1'b1;
        step();
        chk_out("done_in_idle", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0001;
        step();
        chk_out("single_gnt", 4'b0001, 2'd0, 1'b0);
        bus.done = 1'b1;
        step();
        chk_out("single_rel", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;

        // Rotation from ptr=0 with every client requesting.
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("rot%0d_gnt", k), rot_gnt[k], rot_id[k], 1'b0);
            bus.done = 1'b1;
            step();
            chk_out($sformatf("rot%0d_gap", k), 4'b0000, 2'd0, 1'b0);
            bus.done = 1'b0;
        end
        bus.req = 4'b0000;
        step();

        // Watchdog: eight grant cycles, one timeout cycle, then regrant.
        bus.req = 4'b0100;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_out($sformatf("wd_hold%0d", i), 4'b0100, 2'd2, 1'b0);
        end
        step();
        chk_out("wd_timeout", 4'b0000, 2'd0, 1'b1);
        step();
        chk_out("wd_regrant", 4'b0100, 2'd2, 1'b0);

        // done coinciding with the hold limit is a normal release.
        for (int i = 2; i <= 8; i++) step();
        chk_out("lim_pre", 4'b0100, 2'd2, 1'b0);
        bus.done = 1'b1;
        step();
        chk_out("lim_done_rel", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;
        step();
        chk_out("drop_gnt", 4'b0100, 2'd2, 1'b0);
        bus.req = 4'b0000;
        step();
        chk_out("drop_rel", 4'b0000, 2'd0, 1'b0);

        // Move ptr to 2 by granting and releasing client 1 (ptr currently 3).
        bus.req = 4'b0010;
        step();
        chk_out("fair_c1", 4'b0010, 2'd1, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0011;
        step();
        chk_out("fair_wrap_c0", 4'b0001, 2'd0, 1'b0);
        bus.req = 4'b1111;
        step();
        chk_out("no_preempt1", 4'b0001, 2'd0, 1'b0);
        step();
        chk_out("no_preempt2", 4'b0001, 2'd0, 1'b0);
        bus.done = 1'b1;
        step();
        chk_out("fair_rel", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;
        step();
        chk_out("fair_next_c1", 4'b0010, 2'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
